decoder_3to8: RTL and testbench
===============================

# decoder_3to8

Registered 3-to-8 one-hot decoder with enable. It drives the column-select lines of the LED matrix scan path: `led_array_driver` feeds it the current column index and uses the one-hot result both as the column drive and as the gating term for row data. When disabled, no column is selected.

## Interface

Parameters:
- None. Widths are fixed at 3 → 8.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high. Polarity and synchronicity are fixed.
- `ena`  input  1  decode enable; 0 forces an all-zero result.
- `in`  input  3  binary select index, 0..7. Callers with a wider index connect only the low 3 bits.
- `out`  output  8  one-hot select, registered; `out[i]`=1 iff `ena` and `in`==i.

## Operation

- Next-state value `d`:
  - `ena`=1: `d = 8'b1 << in`. Exactly one bit is set.
  - `ena`=0: `d = 8'h00`.
- Rising `clk`:
  - `rst`=1: `out <= 8'h00`.
  - Otherwise: `out <= d`.
- `rst` takes priority over `ena` and `in` in the same cycle.
- Invariant: `out` is always either all-zero or exactly one-hot. Two or more bits set is a design error.
- Bit mapping is fixed: `in`=0 → `out[0]` ... `in`=7 → `out[7]`. No reversal; any row/column flipping happens in the consumer.
- X/Z on `in` while `ena`=1 is illegal stimulus. The implementation must not create latches; every path assigns `d`.

## Timing

- Latency: 1 cycle. Inputs sampled at edge k appear on `out` after edge k.
- No combinational path from `ena`/`in` to `out`.
- Reset value of `out`: `8'h00`.
- After reset releases, `out` holds `8'h00` until the first non-reset edge with `ena`=1.
- Reset mid-operation: the first edge with `rst`=1 clears `out`, regardless of the previous selection or current inputs.
- Back-to-back index changes update every cycle with no idle cycle. Consecutive `in` values 7 → 0 wrap with no glitch cycle beyond the register.
- `ena` deassertion takes effect one edge later: `out` becomes `8'h00`.
- Throughput: one decode per cycle. No handshake.

## Structure

- No shared package is needed. Optionally define `DEC_IN_W=3` and `DEC_OUT_W=8` in the project's common constants package if one already exists.
- Natural hierarchy: two instances of `decoder_2_to_4`, each with ports `ena`, `in[1:0]`, `out[3:0]`.
  - Low instance: enable `ena & ~in[2]`, output drives `d[3:0]`.
  - High instance: enable `ena & in[2]`, output drives `d[7:4]`.
- `decoder_2_to_4` may itself be built from `decoder_1_to_2` instances.
- The sub-decoders are purely combinational. The output register lives only in the top block, with synchronous reset.

## Test plan

- Reset: hold `rst`=1, `ena`=1, `in`=5 for 2 cycles → `out`=`8'h00`. Release `rst` → `out`=`8'h20` one edge later.
- Exhaustive sweep: `ena`=1, drive `in`=0..7 on successive cycles → `out` = `01,02,04,08,10,20,40,80` hex, each one cycle after its input. Check one-hot every cycle.
- Enable gating: `ena`=0 with every `in` value → `out`=`8'h00`. Toggle `ena` 1→0 at `in`=3: `out` goes `08` → `00` one edge later.
- Reset mid-operation: running sweep at `in`=6, assert `rst` for one cycle → `out`=`00` on that edge. Resume sweep → next edge shows decode of the current `in`.
- Wrap and hold: `in` 7 → 0 back-to-back → `out` goes `80` → `01` with no intermediate value. Hold `in` constant for 10 cycles → `out` stable.
- Randomised: 1000 cycles of random `ena`/`in`/`rst` (rst 5% duty) against a 1-cycle-delayed reference model. Also assert `$onehot0(out)` every cycle.

Source files
------------

// File: rtl/decoder_3to8_pkg.sv
// decoder_3to8 shared widths.
// Imported by the column-select decoder tree.
package decoder_3to8_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  typedef logic [DEC_IN_W-1:0]  dec_idx_t;
  typedef logic [DEC_OUT_W-1:0] dec_sel_t;

endpackage

// File: rtl/decoder_3to8_dec.sv
// Combinational sub-decoders for the column-select tree.
// 1-to-2 leaf and 2-to-4 node, both gated by enable.
module decoder_1_to_2 (
  input  logic       ena,
  input  logic       in,
  output logic [1:0] out
);

  // Gated leaf: one line high when enabled, none otherwise.
  always_comb begin
    out = 2'b00;
    unique case (1'b1)
      (ena && !in): out = 2'b01;
      (ena &&  in): out = 2'b10;
      default:      out = 2'b00;
    endcase
  end

endmodule

module decoder_2_to_4 (
  input  logic       ena,
  input  logic [1:0] in,
  output logic [3:0] out
);

  logic ena_lo;
  logic ena_hi;

  assign ena_lo = ena & ~in[1];
  assign ena_hi = ena &  in[1];

  decoder_1_to_2 u_lo (
    .ena (ena_lo),
    .in  (in[0]),
    .out (out[1:0])
  );

  decoder_1_to_2 u_hi (
    .ena (ena_hi),
    .in  (in[0]),
    .out (out[3:2])
  );

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot column decoder.
// Two 2-to-4 halves split on in[2]; output flopped.
module decoder_3to8
  import decoder_3to8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [DEC_IN_W-1:0]  in,
  output logic [DEC_OUT_W-1:0] out
);

  dec_sel_t d;
  logic     ena_lo;
  logic     ena_hi;

  assign ena_lo = ena & ~in[2];
  assign ena_hi = ena &  in[2];

  decoder_2_to_4 u_lo (
    .ena (ena_lo),
    .in  (in[1:0]),
    .out (d[3:0])
  );

  decoder_2_to_4 u_hi (
    .ena (ena_hi),
    .in  (in[1:0]),
    .out (d[7:4])
  );

  // Output register; reset wins over any decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= d;
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8.
// Directed plan plus random run vs. a power-of-two model.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] in_s = 3'd0;
  logic [7:0] out_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_3to8 dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .in  (in_s),
    .out (out_s)
  );

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic r,
                                       input logic e,
                                       input logic [2:0] i);
    if (r || !e) return 8'h00;
    return 8'(2 ** int'(i));
  endfunction

  task automatic step(input string tag,
                      input logic r,
                      input logic e,
                      input logic [2:0] i);
    logic [7:0] exp;
    logic [7:0] cnt;
    @(negedge clk);
    rst  = r;
    ena  = e;
    in_s = i;
    exp  = model(r, e, i);
    @(posedge clk);
    #1;
    check(tag, out_s, exp);
    cnt = 8'($countones(out_s));
    check("onehot0", {7'd0, cnt <= 8'd1}, 8'd1);
  endtask

  initial begin
    step("rst0", 1'b1, 1'b1, 3'd5);
    step("rst1", 1'b1, 1'b1, 3'd5);
    step("rel",  1'b0, 1'b1, 3'd5);

    for (int k = 0; k < 8; k++)
      step("sweep", 1'b0, 1'b1, 3'(k));

    for (int k = 0; k < 8; k++)
      step("dis", 1'b0, 1'b0, 3'(k));

    step("en3",  1'b0, 1'b1, 3'd3);
    step("off3", 1'b0, 1'b0, 3'd3);

    for (int k = 0; k < 7; k++)
      step("pre", 1'b0, 1'b1, 3'(k));
    step("midrst", 1'b1, 1'b1, 3'd6);
    step("resume", 1'b0, 1'b1, 3'd7);

    step("wrap0", 1'b0, 1'b1, 3'd0);
    step("w7",    1'b0, 1'b1, 3'd7);
    step("w0",    1'b0, 1'b1, 3'd0);

    for (int k = 0; k < 10; k++)
      step("hold", 1'b0, 1'b1, 3'd4);

    for (int k = 0; k < 1000; k++) begin
      step("rand",
           ($urandom_range(99) < 5),
           1'($urandom),
           3'($urandom));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
